// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file, 64-bit cycle/instret counters and prioritised interrupt controller
module csr_unit #(
    parameter int XLEN = 32,
    parameter int NUM_IRQ = 4,
    parameter bit VECTORED_EN = 1'b1,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    input logic [31:0] inst,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] pc,
    input logic csr_rd,
    input logic csr_wr,
    input logic is_mret,
    input logic instret,
    input logic irq_ext,
    input logic irq_timer,
    input logic [NUM_IRQ-1:0] irq_local,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] epc,
    output logic epc_taken
);
    localparam logic [31:0] MIE_MASK = 32'h0000_0880 | (32'((64'd1 << NUM_IRQ) - 64'd1) << 16);
    logic [11:0] addr;
    logic [1:0] op;
    logic st_mie, st_mpie, hit, wr_en, take, unused_bits;
    logic [4:0] code;
    logic [31:0] mie_r, mtvec, mscratch, mepc, mcause, mip, mip_next, pend, old, nv, mstatus, trap_pc;
    logic [63:0] mcycle, minstret;
    assign addr = inst[31:20];
    assign op = inst[13:12];
    assign unused_bits = ^{inst[19:14], inst[11:0], pc[1:0]};
    assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    always_comb begin
        old = '0;
        hit = 1'b1;
        case (addr)
            12'h300: old = mstatus;
            12'h304: old = mie_r;
            12'h305: old = mtvec;
            12'h340: old = mscratch;
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h344: old = mip;
            12'hB00: old = mcycle[31:0];
            12'hB80: old = mcycle[63:32];
            12'hB02: old = minstret[31:0];
            12'hB82: old = minstret[63:32];
            default: hit = 1'b0;
        endcase
    end
    always_comb begin
        mip_next = '0;
        mip_next[7] = irq_timer;
        mip_next[11] = irq_ext;
        mip_next[16 +: NUM_IRQ] = irq_local;
    end
    // lowest local index wins among locals; MEI and MTI override all locals
    always_comb begin
        code = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[16 + i]) code = 5'(16 + i);
        if (pend[7]) code = 5'd7;
        if (pend[11]) code = 5'd11;
    end
    assign pend = mip & mie_r;
    assign take = st_mie && |pend && !is_mret;
    assign nv = op == 2'b01 ? wdata : op == 2'b10 ? old | wdata : old & ~wdata;
    assign wr_en = csr_wr && hit && !take && (op == 2'b01 || (op != 2'b00 && |wdata));
    assign trap_pc = {mtvec[31:2], 2'b00} + (mtvec[1:0] == 2'b01 ? {25'b0, code, 2'b00} : 32'b0);
    assign rdata = csr_rd ? old : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie <= 1'b0;
            st_mpie <= 1'b0;
            mie_r <= '0;
            mtvec <= MTVEC_RESET;
            mscratch <= '0;
            mepc <= '0;
            mcause <= '0;
            mip <= '0;
            mcycle <= '0;
            minstret <= '0;
            epc <= '0;
            epc_taken <= 1'b0;
        end else begin
            mip <= mip_next;
            epc_taken <= 1'b0;
            mcycle <= mcycle + 64'd1;
            minstret <= minstret + 64'(instret);
            // a counter-half write overrides the increment for this cycle
            if (wr_en)
                case (addr)
                    12'h300: begin
                        st_mie <= nv[3];
                        st_mpie <= nv[7];
                    end
                    12'h304: mie_r <= nv & MIE_MASK;
                    12'h305: mtvec <= {nv[31:2], 1'b0, VECTORED_EN && nv[1:0] == 2'b01};
                    12'h340: mscratch <= nv;
                    12'h341: mepc <= {nv[31:2], 2'b00};
                    12'h342: mcause <= nv;
                    12'hB00: mcycle <= {mcycle[63:32], nv};
                    12'hB80: mcycle <= {nv, mcycle[31:0]};
                    12'hB02: minstret <= {minstret[63:32], nv};
                    12'hB82: minstret <= {nv, minstret[31:0]};
                    default: ;
                endcase
            if (is_mret) begin
                st_mie <= st_mpie;
                st_mpie <= 1'b1;
                epc <= mepc;
                epc_taken <= 1'b1;
            end else if (take) begin
                mepc <= {pc[31:2], 2'b00};
                mcause <= {1'b1, 26'b0, code};
                st_mpie <= st_mie;
                st_mie <= 1'b0;
                epc <= trap_pc;
                epc_taken <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed CSR/interrupt vectors checked against a CSR-map model every cycle
module tb_csr_unit;
    localparam int NUM_IRQ = 4;
    localparam bit VECTORED_EN = 1'b1;
    localparam logic [31:0] MTVEC_RESET = 32'h0000_0100;
    localparam logic [31:0] MIE_MASK = 32'h0000_0880 | (32'((1 << NUM_IRQ) - 1) << 16);
    logic clk, rst, csr_rd, csr_wr, is_mret, instret, irq_ext, irq_timer, epc_taken;
    logic [31:0] inst, wdata, pc, rdata, epc;
    logic [NUM_IRQ-1:0] irq_local;
    int tests = 0, fails = 0;
    bit started = 0;
    logic [31:0] m [0:4095];
    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_epc;
    bit m_ept;
    int prio[$];
    csr_unit #(.XLEN(32), .NUM_IRQ(NUM_IRQ), .VECTORED_EN(VECTORED_EN), .MTVEC_RESET(MTVEC_RESET)) dut (
        .clk(clk), .rst(rst), .inst(inst), .wdata(wdata), .pc(pc), .csr_rd(csr_rd), .csr_wr(csr_wr),
        .is_mret(is_mret), .instret(instret), .irq_ext(irq_ext), .irq_timer(irq_timer),
        .irq_local(irq_local), .rdata(rdata), .epc(epc), .epc_taken(epc_taken)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic bit known(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction
    function automatic logic [31:0] mread_raw(input logic [11:0] a);
        case (a)
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return known(a) ? m[a] : 32'h0;
        endcase
    endfunction
    function automatic logic [31:0] mread();
        return csr_rd ? mread_raw(inst[31:20]) : 32'h0;
    endfunction
    function automatic logic [31:0] enc(input logic [11:0] a, input logic [2:0] f);
        return {a, 5'd0, f, 5'd0, 7'h73};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // model: the architectural CSR map advanced once per clock edge
    task automatic step();
        logic [11:0] a;
        logic [1:0] f;
        logic [31:0] pend, old, nv, st, v;
        logic [63:0] oc, oi;
        int code;
        bit take, wr;
        if (rst) begin
            for (int i = 0; i < 4096; i++) m[i] = 32'h0;
            m[12'h305] = MTVEC_RESET;
            m[12'h300] = 32'h1800;
            m_cyc = 0; m_ins = 0; m_epc = 0; m_ept = 0;
            started = 1;
            return;
        end
        a = inst[31:20];
        f = inst[13:12];
        pend = m[12'h344] & m[12'h304];
        code = -1;
        foreach (prio[k]) if (code < 0 && pend[prio[k]]) code = prio[k];
        take = m[12'h300][3] && code >= 0 && !is_mret;
        old = mread_raw(a);
        nv = f == 2'b01 ? wdata : f == 2'b10 ? old | wdata : old & ~wdata;
        wr = csr_wr && !take && known(a) && (f == 2'b01 || (f != 2'b00 && wdata != 0));
        oc = m_cyc; oi = m_ins; st = m[12'h300];
        m_cyc = m_cyc + 1;
        if (instret) m_ins = m_ins + 1;
        m_ept = 0;
        if (wr)
            case (a)
                12'h300: m[a] = 32'h1800 | (nv & 32'h88);
                12'h304: m[a] = nv & MIE_MASK;
                12'h305: m[a] = {nv[31:2], 2'b00} | ((VECTORED_EN && nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
                12'h340, 12'h342: m[a] = nv;
                12'h341: m[a] = nv & ~32'h3;
                12'hB00: m_cyc = {oc[63:32], nv};
                12'hB80: m_cyc = {nv, oc[31:0]};
                12'hB02: m_ins = {oi[63:32], nv};
                12'hB82: m_ins = {nv, oi[31:0]};
                default: ;
            endcase
        if (is_mret) begin
            m[12'h300] = 32'h1880 | (st[7] ? 32'h8 : 32'h0);
            m_epc = m[12'h341];
            m_ept = 1;
        end else if (take) begin
            m[12'h341] = pc & ~32'h3;
            m[12'h342] = 32'h8000_0000 | 32'(code);
            m[12'h300] = 32'h1800 | (st[3] ? 32'h80 : 32'h0);
            m_epc = (m[12'h305] & ~32'h3) + (m[12'h305][1:0] == 2'b01 ? 32'(4 * code) : 32'h0);
            m_ept = 1;
        end
        v = 32'h0;
        v[7] = irq_timer;
        v[11] = irq_ext;
        for (int i = 0; i < NUM_IRQ; i++) v[16 + i] = irq_local[i];
        m[12'h344] = v;
    endtask
    always @(posedge clk) step();
    always @(negedge clk)
        if (started) begin
            check("rdata", rdata, mread());
            check("epc", epc, m_epc);
            check("epc_taken", {31'b0, epc_taken}, {31'b0, m_ept});
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        csr_rd = 0; csr_wr = 0; is_mret = 0; instret = 0;
        repeat (n) tick();
    endtask
    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        inst = enc(a, 3'b010); wdata = 0; csr_rd = 1; csr_wr = 0; is_mret = 0; instret = 0;
        #2;
        check(name, rdata, exp);
        check({name, "_model"}, mread(), exp);
        tick();
        csr_rd = 0;
    endtask
    task automatic wr(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d);
        inst = enc(a, f); wdata = d; csr_rd = 1; csr_wr = 1; is_mret = 0; instret = 0;
        tick();
        csr_wr = 0; csr_rd = 0;
    endtask
    task automatic mret();
        csr_rd = 0; csr_wr = 0; instret = 0; is_mret = 1;
        tick();
        is_mret = 0;
    endtask
    task automatic redirect(input logic [31:0] exp, input string name);
        check({name, "_epc"}, epc, exp);
        check({name, "_taken"}, {31'b0, epc_taken}, 32'd1);
    endtask
    initial begin
        prio = {11, 7};
        for (int i = 0; i < NUM_IRQ; i++) prio.push_back(16 + i);
        rst = 1; inst = 0; wdata = 0; pc = 0; csr_rd = 0; csr_wr = 0; is_mret = 0; instret = 0;
        irq_ext = 0; irq_timer = 0; irq_local = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rd(12'h305, MTVEC_RESET, "rst_mtvec");
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h7C0, 32'h0, "unknown_rd");
        wr(12'h340, 3'b001, 32'hDEAD_BEEF);
        rd(12'h340, 32'hDEAD_BEEF, "csrrw");
        wr(12'h340, 3'b010, 32'h0000_0010);
        rd(12'h340, 32'hDEAD_BEFF, "csrrs");
        wr(12'h340, 3'b011, 32'h0000_000F);
        rd(12'h340, 32'hDEAD_BEF0, "csrrc");
        wr(12'h340, 3'b010, 32'h0);
        rd(12'h340, 32'hDEAD_BEF0, "csrrs_zero");
        wr(12'h340, 3'b000, 32'h1234);
        rd(12'h340, 32'hDEAD_BEF0, "f3_000");
        wr(12'h7C0, 3'b001, 32'h1234);
        rd(12'h7C0, 32'h0, "unknown_wr");
        wr(12'h305, 3'b001, 32'h1001);
        rd(12'h305, 32'h1001, "mtvec_vec");
        wr(12'h304, 3'b001, 32'hFFFF_FFFF);
        rd(12'h304, MIE_MASK, "mie_mask");
        wr(12'h304, 3'b001, 32'h80);
        wr(12'h300, 3'b001, 32'h8);
        rd(12'h300, 32'h1808, "mstatus_mie");
        pc = 32'h40; irq_timer = 1;
        idle(2);
        redirect(32'h101C, "timer_vec");
        irq_timer = 0;
        idle(1);
        check("taken_once", {31'b0, epc_taken}, 32'd0);
        rd(12'h341, 32'h40, "timer_mepc");
        rd(12'h342, 32'h8000_0007, "timer_mcause");
        rd(12'h300, 32'h1880, "timer_mstatus");
        mret();
        redirect(32'h40, "mret");
        rd(12'h300, 32'h1888, "mret_mstatus");
        wr(12'h305, 3'b001, 32'h2000);
        wr(12'h304, 3'b001, 32'h10880);
        pc = 32'h80; irq_ext = 1; irq_timer = 1; irq_local = 4'b0001;
        idle(2);
        redirect(32'h2000, "prio_direct");
        rd(12'h342, 32'h8000_000B, "prio_mcause");
        rd(12'h341, 32'h80, "prio_mepc");
        mret();
        redirect(32'h80, "mret_pending");
        idle(1);
        redirect(32'h2000, "trap_after_mret");
        irq_ext = 0; irq_timer = 0; irq_local = 0;
        idle(2);
        wr(12'h304, 3'b001, 32'h80);
        irq_timer = 1;
        idle(2);
        wr(12'h300, 3'b001, 32'h8);
        inst = enc(12'h340, 3'b001); wdata = 32'h5555; csr_rd = 1; csr_wr = 1; pc = 32'hC0; instret = 1;
        tick();
        csr_wr = 0; instret = 0;
        redirect(32'h2000, "trap_vs_wr");
        irq_timer = 0;
        rd(12'h340, 32'hDEAD_BEF0, "wr_suppressed");
        rd(12'h341, 32'hC0, "wr_mepc");
        rd(12'h300, 32'h1880, "wr_mstatus");
        wr(12'h305, 3'b001, 32'h1001);
        wr(12'h304, 3'b001, 32'hF0000);
        irq_local = 4'b0110;
        idle(2);
        wr(12'h300, 3'b001, 32'h8);
        idle(1);
        redirect(32'h1044, "local_vec");
        irq_local = 0;
        rd(12'h342, 32'h8000_0011, "local_mcause");
        wr(12'hB00, 3'b001, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_drop");
        rd(12'hB80, 32'h1, "mcycleh_carry");
        rd(12'hB00, 32'h1, "mcycle_wrap");
        wr(12'hB80, 3'b001, 32'h5);
        rd(12'hB80, 32'h5, "mcycleh_wr");
        wr(12'hB02, 3'b001, 32'h0);
        wr(12'hB82, 3'b001, 32'h0);
        instret = 1;
        repeat (3) tick();
        instret = 0;
        rd(12'hB02, 32'h3, "minstret");
        mret();
        redirect(32'hC0, "mret_pre_rst");
        rst = 1;
        tick();
        rst = 0;
        check("rst_taken", {31'b0, epc_taken}, 32'd0);
        check("rst_epc", epc, 32'h0);
        rd(12'h300, 32'h1800, "rst2_mstatus");
        rd(12'h305, MTVEC_RESET, "rst2_mtvec");
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
